// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions: IEEE 1149.1 state encodings and opcode helpers.
package jtag_pkg;

  typedef logic [3:0] tap_state_t;

  localparam tap_state_t ST_TLR      = 4'hF;
  localparam tap_state_t ST_RTI      = 4'hC;
  localparam tap_state_t ST_SEL_DR   = 4'h7;
  localparam tap_state_t ST_CAP_DR   = 4'h6;
  localparam tap_state_t ST_SH_DR    = 4'h2;
  localparam tap_state_t ST_EX1_DR   = 4'h1;
  localparam tap_state_t ST_PAUSE_DR = 4'h3;
  localparam tap_state_t ST_EX2_DR   = 4'h0;
  localparam tap_state_t ST_UPD_DR   = 4'h5;
  localparam tap_state_t ST_SEL_IR   = 4'h4;
  localparam tap_state_t ST_CAP_IR   = 4'hE;
  localparam tap_state_t ST_SH_IR    = 4'hA;
  localparam tap_state_t ST_EX1_IR   = 4'h9;
  localparam tap_state_t ST_PAUSE_IR = 4'hB;
  localparam tap_state_t ST_EX2_IR   = 4'h8;
  localparam tap_state_t ST_UPD_IR   = 4'hD;

  // All-ones BYPASS opcode, right-aligned in a 16-bit field for widths 2..16.
  function automatic logic [15:0] bypass_op(input int width);
    bypass_op = 16'((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP controller state machine: 16-state 1149.1 sequencer clocked by TCK,
// exposing the state register and its single-state decodes.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  output logic [3:0] STATE,
  output logic       capture_dr_s,
  output logic       shift_dr_s,
  output logic       update_dr_s,
  output logic       capture_ir_s,
  output logic       shift_ir_s,
  output logic       update_ir_s,
  output logic       tap_rst_s
);

  tap_state_t state_q, state_d;

  // Next-state selection from TMS.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TLR:      state_d = TMS ? ST_TLR      : ST_RTI;
      ST_RTI:      state_d = TMS ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   state_d = TMS ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   state_d = TMS ? ST_EX1_DR   : ST_SH_DR;
      ST_SH_DR:    state_d = TMS ? ST_EX1_DR   : ST_SH_DR;
      ST_EX1_DR:   state_d = TMS ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: state_d = TMS ? ST_EX2_DR   : ST_PAUSE_DR;
      ST_EX2_DR:   state_d = TMS ? ST_UPD_DR   : ST_SH_DR;
      ST_UPD_DR:   state_d = TMS ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   state_d = TMS ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   state_d = TMS ? ST_EX1_IR   : ST_SH_IR;
      ST_SH_IR:    state_d = TMS ? ST_EX1_IR   : ST_SH_IR;
      ST_EX1_IR:   state_d = TMS ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: state_d = TMS ? ST_EX2_IR   : ST_PAUSE_IR;
      ST_EX2_IR:   state_d = TMS ? ST_UPD_IR   : ST_SH_IR;
      ST_UPD_IR:   state_d = TMS ? ST_SEL_DR   : ST_RTI;
      default:     state_d = ST_TLR;
    endcase
  end

  // State register.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state_q <= ST_TLR;
    end else begin
      state_q <= state_d;
    end
  end

  assign STATE        = state_q;
  assign capture_dr_s = (state_q == ST_CAP_DR);
  assign shift_dr_s   = (state_q == ST_SH_DR);
  assign update_dr_s  = (state_q == ST_UPD_DR);
  assign capture_ir_s = (state_q == ST_CAP_IR);
  assign shift_ir_s   = (state_q == ST_SH_IR);
  assign update_ir_s  = (state_q == ST_UPD_IR);
  assign tap_rst_s    = (state_q == ST_TLR);

endmodule

// File: rtl/jtag_tap_core.sv
// JTAG TAP core: controller, instruction register, BYPASS/IDCODE data registers, TDO path.
// Define JTAG_TAP_IDCODE_EN to include the IDCODE register and make it the reset instruction.
module jtag_tap_core
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH     = 4,
  parameter logic [IR_WIDTH-1:0] IDCODE_OP    = 4'h1,
  parameter logic [31:0]         IDCODE_VALUE = 32'h4BA00477
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_EN,
  output logic [3:0]          STATE,
  output logic [IR_WIDTH-1:0] INSTR,
  output logic                CAPTUREDR,
  output logic                SHIFTDR,
  output logic                UPDATEDR,
  output logic                SHIFTIR,
  output logic                UPDATEIR,
  output logic                TAP_RST,
  input  logic                EXT_TDO
);

  localparam logic [15:0]         BYPASS_WIDE = bypass_op(IR_WIDTH);
  localparam logic [IR_WIDTH-1:0] BYPASS_OP   = BYPASS_WIDE[IR_WIDTH-1:0];
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RESET_OP    = IDCODE_OP;
`else
  localparam logic [IR_WIDTH-1:0] RESET_OP    = BYPASS_OP;
`endif

  logic                capture_dr_s, shift_dr_s, update_dr_s;
  logic                capture_ir_s, shift_ir_s, update_ir_s, tap_rst_s;
  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d, instr_q, instr_d;
  logic                bypass_q, bypass_d;
  logic                sel_bypass_s, sel_ext_s, dr_tdo_s;
  logic                tdo_q, tdo_d, tdo_en_q, tdo_en_d;

  jtag_tap_fsm u_fsm (
    .TCK          (TCK),
    .TRST         (TRST),
    .TMS          (TMS),
    .STATE        (STATE),
    .capture_dr_s (capture_dr_s),
    .shift_dr_s   (shift_dr_s),
    .update_dr_s  (update_dr_s),
    .capture_ir_s (capture_ir_s),
    .shift_ir_s   (shift_ir_s),
    .update_ir_s  (update_ir_s),
    .tap_rst_s    (tap_rst_s)
  );

`ifdef JTAG_TAP_IDCODE_EN
  logic        sel_idcode_s;
  logic [31:0] idcode_q, idcode_d;

  assign sel_bypass_s = (instr_q == BYPASS_OP);
  assign sel_idcode_s = !sel_bypass_s && (instr_q == IDCODE_OP);
  assign sel_ext_s    = !sel_bypass_s && !sel_idcode_s;
  assign dr_tdo_s     = sel_ext_s ? EXT_TDO : (sel_idcode_s ? idcode_q[0] : bypass_q);

  // IDCODE capture and right shift.
  always_comb begin
    if (capture_dr_s && sel_idcode_s) begin
      idcode_d = IDCODE_VALUE;
    end else if (shift_dr_s && sel_idcode_s) begin
      idcode_d = {TDI, idcode_q[31:1]};
    end else begin
      idcode_d = idcode_q;
    end
  end

  // IDCODE register.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      idcode_q <= 32'h0000_0000;
    end else begin
      idcode_q <= idcode_d;
    end
  end
`else
  // Without the IDCODE register its opcode falls back to BYPASS.
  assign sel_bypass_s = (instr_q == BYPASS_OP) || (instr_q == IDCODE_OP);
  assign sel_ext_s    = !sel_bypass_s;
  assign dr_tdo_s     = sel_ext_s ? EXT_TDO : bypass_q;
`endif

  // Instruction shift register and active instruction; update lands on the edge leaving Update-IR.
  always_comb begin
    if (tap_rst_s) begin
      instr_d = RESET_OP;
    end else if (update_ir_s) begin
      instr_d = ir_sr_q;
    end else begin
      instr_d = instr_q;
    end
    if (capture_ir_s) begin
      ir_sr_d = {{(IR_WIDTH-1){1'b0}}, 1'b1};
    end else if (shift_ir_s) begin
      ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
    end else begin
      ir_sr_d = ir_sr_q;
    end
    if (capture_dr_s && sel_bypass_s) begin
      bypass_d = 1'b0;
    end else if (shift_dr_s && sel_bypass_s) begin
      bypass_d = TDI;
    end else begin
      bypass_d = bypass_q;
    end
  end

  // Rising-edge registers.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      ir_sr_q  <= {IR_WIDTH{1'b0}};
      instr_q  <= RESET_OP;
      bypass_q <= 1'b0;
    end else begin
      ir_sr_q  <= ir_sr_d;
      instr_q  <= instr_d;
      bypass_q <= bypass_d;
    end
  end

  // TDO source mux, launched on the falling edge.
  always_comb begin
    if (shift_ir_s) begin
      tdo_d = ir_sr_q[0];
    end else if (shift_dr_s) begin
      tdo_d = dr_tdo_s;
    end else begin
      tdo_d = 1'b0;
    end
    tdo_en_d = shift_ir_s || shift_dr_s;
  end

  // Falling-edge output registers.
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign TDO       = tdo_q;
  assign TDO_EN    = tdo_en_q;
  assign INSTR     = instr_q;
  assign CAPTUREDR = capture_dr_s && sel_ext_s;
  assign SHIFTDR   = shift_dr_s && sel_ext_s;
  assign UPDATEDR  = update_dr_s && sel_ext_s;
  assign SHIFTIR   = shift_ir_s;
  assign UPDATEIR  = update_ir_s;
  assign TAP_RST   = tap_rst_s;

endmodule

// File: tb/tb_jtag_tap_core.sv
// Bench for jtag_tap_core: table-driven TAP model checked every TCK falling edge,
// directed scenarios with literal expectations, then randomized TMS/TDI/EXT_TDO traffic.
module tb_jtag_tap_core;

  localparam int          W     = 4;
  localparam logic [3:0]  IDOP  = 4'h1;
  localparam logic [31:0] IDVAL = 32'h4BA00477;
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [3:0]  RST_OP = IDOP;
  localparam bit          ID_EN  = 1'b1;
`else
  localparam logic [3:0]  RST_OP = 4'hF;
  localparam bit          ID_EN  = 1'b0;
`endif

  logic TCK = 1'b0;
  logic TRST, TMS, TDI, EXT_TDO;
  logic TDO, TDO_EN, CAPTUREDR, SHIFTDR, UPDATEDR, SHIFTIR, UPDATEIR, TAP_RST;
  logic [3:0] STATE;
  logic [W-1:0] INSTR;

  jtag_tap_core #(.IR_WIDTH(W), .IDCODE_OP(IDOP), .IDCODE_VALUE(IDVAL)) dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
    .STATE(STATE), .INSTR(INSTR), .CAPTUREDR(CAPTUREDR), .SHIFTDR(SHIFTDR),
    .UPDATEDR(UPDATEDR), .SHIFTIR(SHIFTIR), .UPDATEIR(UPDATEIR), .TAP_RST(TAP_RST),
    .EXT_TDO(EXT_TDO)
  );

  always #5 TCK = ~TCK;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: next-state nibble tables indexed by state code, plus register contents.
  logic [63:0] next0_tab, next1_tab;
  logic [3:0]  m_state, m_instr, m_ir;
  logic        m_byp, e_tdo, e_tdo_en;
  logic [31:0] m_id;
  int          cmp_kind;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
    logic [63:0] t;
    t = tms ? next1_tab : next0_tab;
    return t[int'(s)*4 +: 4];
  endfunction

  // 0 = bypass, 1 = idcode, 2 = external
  function automatic int dr_kind(input logic [3:0] op);
    if (op == 4'hF) return 0;
    if (op == IDOP) return ID_EN ? 1 : 0;
    return 2;
  endfunction

  task automatic model_reset();
    m_state = 4'hF; m_instr = RST_OP; m_ir = 4'h0; m_byp = 1'b0; m_id = 32'h0;
    e_tdo = 1'b0; e_tdo_en = 1'b0;
  endtask

  task automatic model_rise(input logic tms, input logic tdi);
    int k;
    k = dr_kind(m_instr);
    if (m_state == 4'hF) m_instr = RST_OP;
    if (m_state == 4'hE) m_ir = 4'h1;
    if (m_state == 4'hA) m_ir = (m_ir >> 1) | (tdi ? 4'b1000 : 4'b0000);
    if (m_state == 4'hD) m_instr = m_ir;
    if (m_state == 4'h6 && k == 0) m_byp = 1'b0;
    if (m_state == 4'h6 && k == 1) m_id = IDVAL;
    if (m_state == 4'h2 && k == 0) m_byp = tdi;
    if (m_state == 4'h2 && k == 1) m_id = (m_id >> 1) | (tdi ? 32'h8000_0000 : 32'h0);
    m_state = tap_next(m_state, tms);
    k = dr_kind(m_instr);
    e_tdo_en = (m_state == 4'h2) || (m_state == 4'hA);
    if (m_state == 4'hA) e_tdo = m_ir[0];
    else if (m_state == 4'h2) e_tdo = (k == 2) ? EXT_TDO : ((k == 1) ? m_id[0] : m_byp);
    else e_tdo = 1'b0;
  endtask

  // Per-cycle comparison against the model, after TDO has launched.
  always @(negedge TCK) begin
    if (chk_en) begin
      #1;
      cmp_kind = dr_kind(m_instr);
      cmp("state", STATE, m_state);
      cmp("instr", INSTR, m_instr);
      cmp("tdo", TDO, e_tdo);
      cmp("tdo_en", TDO_EN, e_tdo_en);
      cmp("capturedr", CAPTUREDR, (m_state == 4'h6) && (cmp_kind == 2));
      cmp("shiftdr", SHIFTDR, (m_state == 4'h2) && (cmp_kind == 2));
      cmp("updatedr", UPDATEDR, (m_state == 4'h5) && (cmp_kind == 2));
      cmp("shiftir", SHIFTIR, m_state == 4'hA);
      cmp("updateir", UPDATEIR, m_state == 4'hD);
      cmp("tap_rst", TAP_RST, m_state == 4'hF);
    end
  end

  task automatic cycle(input logic tms, input logic tdi, input logic ext);
    TMS = tms; TDI = tdi; EXT_TDO = ext;
    @(posedge TCK); #1;
    model_rise(tms, tdi);
    @(negedge TCK); #2;
  endtask

  task automatic tms_walk(input logic [7:0] seq, input int n);
    for (int i = 0; i < n; i++) cycle(seq[i], 1'b0, 1'b0);
  endtask

  task automatic load_ir(input logic [3:0] op);
    tms_walk(8'b0011, 4);
    for (int i = 0; i < 4; i++) cycle(i == 3, op[i], 1'b0);
    tms_walk(8'b01, 2);
  endtask

  // Asynchronous reset between edges; outputs must react with no TCK edge.
  task automatic reset_now();
    TRST = 1'b0;
    #1;
    cmp("rst_state", STATE, 4'hF);
    cmp("rst_instr", INSTR, RST_OP);
    cmp("rst_tdo_en", TDO_EN, 1'b0);
    cmp("rst_tdo", TDO, 1'b0);
    model_reset();
    #1;
    TRST = 1'b1;
  endtask

  logic [31:0] id_got;
  logic [3:0]  ir_got, byp_got;
  logic [2:0]  op_got;

  initial begin
    next0_tab = 64'hCACC_BABA_62CE_3232;
    next1_tab = 64'hF977_89DD_417F_0155;
    TRST = 1'b1; TMS = 1'b1; TDI = 1'b0; EXT_TDO = 1'b0;
    #1;
    TRST = 1'b0;
    #1;
    cmp("por_state", STATE, 4'hF);
    cmp("por_instr", INSTR, RST_OP);
    cmp("por_tdo_en", TDO_EN, 1'b0);
    cmp("por_tap_rst", TAP_RST, 1'b1);
    model_reset();
    @(negedge TCK); #2;
    TRST = 1'b1;
    chk_en = 1'b1;

    // Five TMS=1 edges reach Test-Logic-Reset
    cycle(1'b0, 1'b0, 1'b0);
    cmp("rti", STATE, 4'hC);
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    cmp("tlr_from_rti", STATE, 4'hF);
    cycle(1'b0, 1'b0, 1'b0);
    cmp("tlr_to_rti", STATE, 4'hC);
    tms_walk(8'b0011, 4);
    cmp("shir", STATE, 4'hA);
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    cmp("tlr_from_shir", STATE, 4'hF);
    cycle(1'b0, 1'b0, 1'b0);

    // Reset-instruction data register, LSB first
    tms_walk(8'b001, 3);
    cmp("shdr", STATE, 4'h2);
    for (int i = 0; i < 32; i++) begin
      id_got[i] = TDO;
      cycle(i == 31, 1'b0, 1'b0);
    end
    cmp("idcode_stream", id_got, ID_EN ? IDVAL : 32'h0);
    tms_walk(8'b01, 2);

    // Capture-IR pattern and loading BYPASS
    tms_walk(8'b0011, 4);
    for (int i = 0; i < 4; i++) begin
      ir_got[i] = TDO;
      cycle(i == 3, 1'b1, 1'b0);
    end
    cmp("ir_capture", ir_got, 4'b0001);
    cycle(1'b1, 1'b0, 1'b0);
    cmp("updir", UPDATEIR, 1'b1);
    cmp("instr_held_in_updir", INSTR, RST_OP);
    cycle(1'b0, 1'b0, 1'b0);
    cmp("instr_bypass", INSTR, 4'hF);

    // BYPASS one-bit delay across a Pause-DR / Exit2-DR resume
    tms_walk(8'b001, 3);
    cmp("bypass_no_shiftdr", SHIFTDR, 1'b0);
    byp_got[0] = TDO; cycle(1'b0, 1'b1, 1'b0);
    byp_got[1] = TDO; cycle(1'b0, 1'b0, 1'b0);
    byp_got[2] = TDO; cycle(1'b1, 1'b1, 1'b0);
    tms_walk(8'b010, 3);
    cmp("ex2_resume", STATE, 4'h2);
    byp_got[3] = TDO; cycle(1'b1, 1'b1, 1'b0);
    cmp("bypass_stream", byp_got, 4'b1010);
    tms_walk(8'b01, 2);

    // External instruction strobes and EXT_TDO passthrough
    load_ir(4'h5);
    cmp("instr_ext", INSTR, 4'h5);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cmp("ext_capturedr", CAPTUREDR, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cmp("ext_shiftdr", SHIFTDR, 1'b1);
    cmp("ext_tdo_hi", TDO, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    cmp("ext_tdo_lo", TDO, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cmp("ext_shiftdr_off", SHIFTDR, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cmp("ext_updatedr", UPDATEDR, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    cmp("ext_updatedr_off", UPDATEDR, 1'b0);

    // Opcode 1: IDCODE when built in, otherwise BYPASS
    load_ir(IDOP);
    tms_walk(8'b001, 3);
    cmp("op1_no_shiftdr", SHIFTDR, 1'b0);
    for (int i = 0; i < 3; i++) begin
      op_got[i] = TDO;
      cycle(i == 2, 1'b0, 1'b0);
    end
    cmp("op1_stream", op_got, ID_EN ? 3'b111 : 3'b000);
    tms_walk(8'b01, 2);

    // Reset in the middle of an external shift
    load_ir(4'h5);
    tms_walk(8'b001, 3);
    cycle(1'b0, 1'b1, 1'b1);
    cmp("pre_rst_tdo_en", TDO_EN, 1'b1);
    reset_now();
    cycle(1'b0, 1'b0, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) reset_now();
      cycle($urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    chk_en = 1'b0;
    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_tap_core.md
JTAG_TAP_CORE -- requirements
Module: jtag_tap_core

Interface
REQ-001 Parameter IR_WIDTH, default 4, instruction register width, legal 2..16.
REQ-002 Parameter IDCODE_OP, default 4'h1, opcode selecting IDCODE register, IR_WIDTH bits.
REQ-003 Parameter IDCODE_VALUE, default 32'h4BA00477, device ID; bit 0 SHALL be 1.
REQ-004 TCK  in  1  test clock; sole clock; state and registers on rising edge, TDO on falling edge.
REQ-005 TRST  in  1  asynchronous active-low reset.
REQ-006 TMS  in  1  mode select, sampled on TCK rising edge.
REQ-007 TDI  in  1  serial data in.
REQ-008 TDO  out  1  serial data out.
REQ-009 TDO_EN  out  1  high while TDO carries valid shift data.
REQ-010 STATE  out  4  current TAP state, standard 1149.1 encoding.
REQ-011 INSTR  out  IR_WIDTH  active (updated) instruction.
REQ-012 CAPTUREDR, SHIFTDR, UPDATEDR  out  1 each  external DR strobes, asserted only for external instructions.
REQ-013 SHIFTIR, UPDATEIR, TAP_RST  out  1 each  state decodes.
REQ-014 EXT_TDO  in  1  serial out of selected external data register.

Function
REQ-015 FSM SHALL implement all 16 1149.1 states and transitions; encodings F,C,7,6,2,1,3,0,5,4,E,A,9,B,8,D for TLR,RTI,SelDR,CapDR,ShDR,Ex1DR,PauseDR,Ex2DR,UpdDR,SelIR,CapIR,ShIR,Ex1IR,PauseIR,Ex2IR,UpdIR.
REQ-016 Exit2-DR/IR with TMS=0 SHALL go to Shift-DR/IR; with TMS=1 to Update-DR/IR.
REQ-017 Five consecutive TMS=1 rising edges SHALL reach TLR from any state.
REQ-018 All strobes are combinational decodes of the STATE register (zero latency, glitch-free); TAP_RST=1 in TLR.
REQ-019 Capture-IR SHALL load IR shift register with 1 in bit 0, 0 in all others.
REQ-020 Shift-IR SHALL shift right: new MSB=TDI; Update-IR SHALL copy shift register to INSTR.
REQ-021 TLR SHALL force INSTR to reset instruction each cycle.
REQ-022 All-ones opcode = BYPASS: 1-bit register, captures 0, shifts TDI.
REQ-023 IDCODE_OP (when enabled): 32-bit register captures IDCODE_VALUE, shifts right with TDI in at MSB.
REQ-024 Any other opcode = external; CAPTUREDR/SHIFTDR/UPDATEDR follow state; TDO source EXT_TDO.
REQ-025 TDO SHALL update on TCK falling edge: Shift-IR -> IR bit 0; Shift-DR -> selected DR bit 0/EXT_TDO; else 0.
REQ-026 TDO_EN SHALL update on same falling edge, 1 exactly in Shift-IR/Shift-DR.
REQ-027 Update occurs on the rising edge leaving Update-IR/DR state, not entering it.

Reset
REQ-028 TRST low SHALL immediately force STATE=TLR, INSTR=reset instruction, TDO=0, TDO_EN=0, shift registers 0.
REQ-029 Reset instruction = IDCODE_OP when enabled, else BYPASS.
REQ-030 TRST assertion mid-shift SHALL discard partial data; INSTR unchanged except forced to reset value.

Configuration
REQ-031 Macro JTAG_TAP_IDCODE_EN: defined -> IDCODE register and opcode present.
REQ-032 Undefined -> no IDCODE register; IDCODE_OP decodes as BYPASS; reset instruction BYPASS.

Structure
REQ-033 Package jtag_pkg: 4-bit state encoding constants, state type, BYPASS opcode function of width.
REQ-034 Sub-module jtag_tap_fsm: TMS/TCK/TRST in, STATE plus decodes out; registers/mux in top.

Verification
REQ-035 TRST low in Shift-DR -> STATE=4'hF, INSTR=4'h1, TDO_EN=0 without TCK edge.
REQ-036 From RTI, TMS=1 x5 -> STATE=4'hF; TMS=0 -> 4'hC.
REQ-037 After reset, reach Shift-DR, 32 shifts -> TDO stream LSB-first equals 32'h4BA00477.
REQ-038 Capture-IR then 4 shifts -> TDO 1,0,0,0; shift in 4'hF, Update-IR -> INSTR=4'hF, BYPASS.
REQ-039 BYPASS, shift TDI 1,0,1,1 -> TDO 0,1,0,1 (one-bit delay); Pause-DR/Exit2-DR TMS=0 resumes Shift-DR.
REQ-040 INSTR=4'h5 -> CAPTUREDR/SHIFTDR/UPDATEDR pulse in matching states, TDO mirrors EXT_TDO; macro undefined -> 4'h1 behaves as BYPASS.
